// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request handshake, skid buffer
// for words returned under a stall, and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PCWrite_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] BranchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] IF_ID_PC_o,
  output logic [31:0] IF_ID_Instr_o,
  output logic        IF_ID_Valid_o,
  output logic [31:0] PC_o
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_drain_addr;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic        w_hold;

  assign w_hold = Stall_i | ~PCWrite_i;

  // A squashed request keeps its address on the bus until memory completes it.
  assign imem_req_o  = ((r_state == S_FETCH) || (r_state == S_DRAIN)) & ~rst_i;
  assign imem_addr_o = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

  assign IF_ID_PC_o    = r_ifid_pc;
  assign IF_ID_Instr_o = r_ifid_instr;
  assign IF_ID_Valid_o = r_ifid_valid;
  assign PC_o          = r_pc;

  // IF -> ID boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_FETCH;
      r_pc         <= PC_RESET;
      r_buf        <= NOP_INSTR;
      r_ifid_pc    <= 32'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (Flush_i) begin
      r_pc         <= BranchTarget_i;
      r_buf        <= NOP_INSTR;
      r_ifid_pc    <= 32'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      if (r_state == S_FETCH && !imem_ready_i) begin
        r_drain_addr <= r_pc;
        r_state      <= S_DRAIN;
      end else if (r_state == S_DRAIN && !imem_ready_i) begin
        r_state <= S_DRAIN;
      end else begin
        r_state <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready_i) begin
            if (w_hold) begin
              r_buf   <= imem_rdata_i;
              r_state <= S_HOLD;
            end else begin
              r_ifid_pc    <= r_pc;
              r_ifid_instr <= imem_rdata_i;
              r_ifid_valid <= 1'b1;
              r_pc         <= r_pc + 32'd4;
            end
          end else if (!w_hold) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!w_hold) begin
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= r_buf;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_pc + 32'd4;
            r_state      <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ready_i) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pcw, stall, flush, rdy;
  logic [31:0] tgt, rdata;
  logic        req, ifv;
  logic [31:0] addr, ifpc, ifinstr, pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        ifv;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk_i(clk), .rst_i(rst), .PCWrite_i(pcw), .Stall_i(stall),
    .Flush_i(flush), .BranchTarget_i(tgt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ready_i(rdy),
    .imem_rdata_i(rdata), .IF_ID_PC_o(ifpc), .IF_ID_Instr_o(ifinstr),
    .IF_ID_Valid_o(ifv), .PC_o(pc)
  );

  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, "req",     {31'd0, req}, {31'd0, e.req});
      chk(e.tag, "addr",    addr,         e.addr);
      chk(e.tag, "pc",      pc,           e.pc);
      chk(e.tag, "ifid_pc", ifpc,         e.ifpc);
      chk(e.tag, "ifid_in", ifinstr,      e.ifinstr);
      chk(e.tag, "ifid_v",  {31'd0, ifv}, {31'd0, e.ifv});
    end
  end

  task automatic cyc(input string tag, input logic r, input logic st,
                     input logic pw, input logic fl, input logic [31:0] t,
                     input logic rd, input logic [31:0] d,
                     input logic er, input logic [31:0] ea, input logic [31:0] epc,
                     input logic [31:0] eifpc, input logic [31:0] eifi,
                     input logic eiv);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = st; pcw = pw; flush = fl; tgt = t; rdy = rd; rdata = d;
    e.tag = tag; e.req = er; e.addr = ea; e.pc = epc;
    e.ifpc = eifpc; e.ifinstr = eifi; e.ifv = eiv;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; pcw = 1'b1; stall = 1'b0; flush = 1'b0; rdy = 1'b0;
    tgt = 32'd0; rdata = 32'd0;
    repeat (2) @(posedge clk);

    // reset state, request gated while rst is high
    cyc("rst",   1,0,1,0,32'h0, 0,32'h0,            0,32'h0,32'h0, 32'h0,NOP,0);
    // zero-wait streaming
    cyc("t1c1",  0,0,1,0,32'h0, 1,iw(32'h0),        1,32'h0,32'h0, 32'h0,NOP,0);
    cyc("t1c2",  0,0,1,0,32'h0, 1,iw(32'h4),        1,32'h4,32'h4, 32'h0,iw(32'h0),1);
    cyc("t1c3",  0,0,1,0,32'h0, 1,iw(32'h8),        1,32'h8,32'h8, 32'h4,iw(32'h4),1);
    cyc("t1c4",  0,0,1,0,32'h0, 1,iw(32'hC),        1,32'hC,32'hC, 32'h8,iw(32'h8),1);
    cyc("t1rst", 1,0,1,0,32'h0, 1,iw(32'h10),       0,32'h10,32'h10, 32'hC,iw(32'hC),1);
    // two wait states
    cyc("d1",    0,0,1,0,32'h0, 0,32'h0,            1,32'h0,32'h0, 32'h0,NOP,0);
    cyc("d2",    0,0,1,0,32'h0, 0,32'h0,            1,32'h0,32'h0, 32'h0,NOP,0);
    cyc("d3",    0,0,1,0,32'h0, 1,32'h00A00093,     1,32'h0,32'h0, 32'h0,NOP,0);
    cyc("d4",    0,0,1,0,32'h0, 0,32'h0,            1,32'h4,32'h4, 32'h0,32'h00A00093,1);
    cyc("d5",    0,0,1,0,32'h0, 1,iw(32'h4),        1,32'h4,32'h4, 32'h0,NOP,0);
    // hold coincident with ready at PC 8, Stall then PCWrite=0
    cyc("h1",    0,1,1,0,32'h0, 1,iw(32'h8),        1,32'h8,32'h8, 32'h4,iw(32'h4),1);
    cyc("h2",    0,1,1,0,32'h0, 0,32'hBAD0_0001,    0,32'h8,32'h8, 32'h4,iw(32'h4),1);
    cyc("h3",    0,0,0,0,32'h0, 0,32'hBAD0_0002,    0,32'h8,32'h8, 32'h4,iw(32'h4),1);
    cyc("h4",    0,0,1,0,32'h0, 0,32'h0,            0,32'h8,32'h8, 32'h4,iw(32'h4),1);
    cyc("h5",    0,0,1,0,32'h0, 1,iw(32'hC),        1,32'hC,32'hC, 32'h8,iw(32'h8),1);
    // flush with request to 0x10 outstanding
    cyc("f1",    0,0,1,0,32'h0, 0,32'h0,            1,32'h10,32'h10, 32'hC,iw(32'hC),1);
    cyc("f2",    0,0,1,1,32'h40,0,32'h0,            1,32'h10,32'h10, 32'hC,NOP,0);
    cyc("f3",    0,0,1,0,32'h0, 0,32'h0,            1,32'h10,32'h40, 32'h0,NOP,0);
    cyc("f4",    0,0,1,0,32'h0, 1,32'hDEAD_BEEF,    1,32'h10,32'h40, 32'h0,NOP,0);
    cyc("f5",    0,0,1,0,32'h0, 1,iw(32'h40),       1,32'h40,32'h40, 32'h0,NOP,0);
    cyc("f6",    0,0,1,0,32'h0, 0,32'h0,            1,32'h44,32'h44, 32'h40,iw(32'h40),1);
    // flush and hold together while in HOLD
    cyc("g1",    0,1,1,0,32'h0, 1,iw(32'h44),       1,32'h44,32'h44, 32'h40,NOP,0);
    cyc("g2",    0,1,1,1,32'h100,0,32'h0,           0,32'h44,32'h44, 32'h40,NOP,0);
    cyc("g3",    0,0,1,0,32'h0, 0,32'h0,            1,32'h100,32'h100, 32'h0,NOP,0);
    cyc("g4",    0,0,1,0,32'h0, 1,iw(32'h100),      1,32'h100,32'h100, 32'h0,NOP,0);
    cyc("g5",    0,0,1,1,32'hFFFF_FFFC,1,32'h0BAD,  1,32'h104,32'h104, 32'h100,iw(32'h100),1);
    // PC wrap, then reset while a request waits
    cyc("w1",    0,0,1,0,32'h0, 1,iw(32'hFFFF_FFFC), 1,32'hFFFF_FFFC,32'hFFFF_FFFC, 32'h0,NOP,0);
    cyc("w2",    0,0,1,0,32'h0, 1,iw(32'h0),        1,32'h0,32'h0, 32'hFFFF_FFFC,iw(32'hFFFF_FFFC),1);
    cyc("w3",    0,1,1,0,32'h0, 0,32'h0,            1,32'h4,32'h4, 32'h0,iw(32'h0),1);
    cyc("w4",    1,0,1,0,32'h0, 0,32'h0,            0,32'h4,32'h4, 32'h0,iw(32'h0),1);
    cyc("w5",    0,0,1,0,32'h0, 0,32'h0,            1,32'h0,32'h0, 32'h0,NOP,0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of ID-stage hazard detection.
- Owns the PC register, the instruction-memory request handshake, and the IF/ID pipeline register.
- Consumes PCWrite/Stall from hazard detection and Flush/branch target from ID.
- Delivers {PC, instruction, valid} to ID. Inserts bubbles when fetch is not complete.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction written into IF/ID for bubbles and flushes (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- PCWrite_i  in  1  0 = hold PC (from hazard detection).
- Stall_i  in  1  1 = hold IF/ID (from hazard detection).
- Flush_i  in  1  branch taken in ID; squash fetch and redirect.
- BranchTarget_i  in  32  redirect PC, valid when Flush_i=1.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address (= PC).
- imem_ready_i  in  1  imem_rdata_i valid; completes the request this cycle.
- imem_rdata_i  in  32  fetched instruction.
- IF_ID_PC_o  out  32  PC of the instruction held in IF/ID.
- IF_ID_Instr_o  out  32  instruction held in IF/ID.
- IF_ID_Valid_o  out  1  1 = real instruction, 0 = bubble.
- PC_o  out  32  current PC.

Behaviour:
- Define hold = Stall_i | ~PCWrite_i.
- Reset (rst_i=1 at an edge), from any state, mid-request included:
  - PC=PC_RESET; state=FETCH; IF_ID_PC_o=0; IF_ID_Instr_o=NOP_INSTR; IF_ID_Valid_o=0; skid buffer cleared.
  - imem_req_o=0 whenever rst_i=1 (combinational gate).
  - First request issues in the first cycle after rst_i falls.
- imem_req_o = (state==FETCH || state==DRAIN) & ~rst_i.
- imem_addr_o = PC in FETCH; in DRAIN, the latched address of the squashed request.
- Address must stay stable while req=1 and ready=0.
- Memory may return ready in the same cycle as req (zero wait states) or after N cycles.
- States: FETCH, HOLD, DRAIN.
- Priority per cycle: rst_i > Flush_i > hold > normal.
- FETCH:
  - ready=1, no hold, no flush: IF/ID <= {PC, rdata, 1}; PC <= PC+4; stay in FETCH. This gives one instruction per cycle with zero-wait memory.
  - ready=1, hold=1: rdata goes into the skid buffer; IF/ID unchanged; PC unchanged; go to HOLD.
  - ready=0, no hold: IF/ID valid <= 0, instr <= NOP_INSTR (bubble).
  - ready=0, hold=1: IF/ID unchanged.
- HOLD:
  - imem_req_o=0.
  - While hold=1: everything unchanged.
  - When hold=0: IF/ID <= {PC, buffer, 1}; PC <= PC+4; go to FETCH. The next request issues the following cycle.
- Flush_i=1, any state:
  - IF/ID <= {0, NOP_INSTR, 0}; PC <= BranchTarget_i; skid buffer discarded.
  - Flush overrides hold.
  - If in FETCH with ready=0 (request outstanding): latch the old address and go to DRAIN.
  - Otherwise (FETCH with ready=1, or HOLD): go to FETCH; returned data is discarded.
- DRAIN:
  - Keep requesting the latched old address until ready=1; discard the data; go to FETCH (new PC).
  - IF/ID stays a bubble.
  - A further Flush_i in DRAIN updates PC only; still drain.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0. BranchTarget_i is taken as-is, with no alignment check.
- Invariant: PC never changes in a cycle where hold=1 and Flush_i=0.
- Invariant: no instruction is lost or duplicated across stalls.

Test Plan:
- Reset, then ready tied 1, no hold: IF_ID_PC_o sequence 0,4,8,12 on consecutive cycles; Valid=1; imem_addr_o one word ahead.
- ready asserted 2 cycles after each req (rdata=32'h00A00093 at PC 0): IF/ID shows 2 bubbles (Valid=0, instr 32'h13) then {0, 32'h00A00093, 1}; PC=4 afterwards.
- hold=1 for 3 cycles coincident with ready=1 at PC 8: IF/ID and PC frozen; req=0 during HOLD. After release, IF_ID_PC_o=8 with the buffered word, then PC 12 is fetched.
- Flush_i with BranchTarget_i=32'h40 while a request to 0x10 is outstanding: IF/ID bubble; DRAIN keeps addr 0x10 until ready; its data is dropped. Next req addr=0x40; IF_ID_PC_o=0x40.
- Flush and hold in the same cycle while in HOLD: buffer dropped; PC=target; next cycle req=1 at target.
- PC=32'hFFFF_FFFC fetched: next imem_addr_o=0. rst_i asserted mid-wait: req=0 that cycle, PC=PC_RESET, Valid=0.
